// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_resp
// Description : Multi-cycle slave responder for the data_sram_* bus. It takes
//               one request at a time over a valid/ready handshake, inserts
//               WAIT_CYCLES wait states, performs lane-masked byte/half/word
//               stores and sign/zero-extended loads, and flags misaligned or
//               malformed accesses.
//               Optional macro DATA_SRAM_STAT_EN enables saturating 16-bit
//               load/store/error counters; without it the counts read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_resp #(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic [2:0]  data_sram_mode,
  input  logic [2:0]  data_sram_write_mode,
  input  logic        data_sram_us,
  output logic        data_sram_ready,
  output logic        data_sram_rvalid,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_err,
  output logic [15:0] data_sram_rd_cnt,
  output logic [15:0] data_sram_wr_cnt,
  output logic [15:0] data_sram_err_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int         AW        = DEPTH_LOG2 + 2;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]          state;
  logic [3:0]          wait_cnt;
  logic [AW-1:0]       addr_q;
  logic [31:0]         wdata_q;
  logic                we_q;
  logic [2:0]          size_q;
  logic                us_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [31:0]         mem [0:(1<<DEPTH_LOG2)-1];

  logic                accept;
  logic                go_resp;
  logic [AW-1:0]       req_addr;
  logic [31:0]         req_wdata;
  logic                req_we;
  logic [2:0]          req_size;
  logic                req_us;
  logic                req_err;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [3:0]          lane_en;
  logic [31:0]         lane_data;

  // Upper address bits are intentionally ignored so addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^data_sram_addr[31:AW];

  assign accept = (state == S_IDLE) && data_sram_en;

  // With zero wait states the access happens on the acceptance edge, so the
  // live bus fields are used in IDLE; otherwise the latched copy is used.
  assign req_addr  = (state == S_IDLE) ? data_sram_addr[AW-1:0] : addr_q;
  assign req_wdata = (state == S_IDLE) ? data_sram_wdata : wdata_q;
  assign req_we    = (state == S_IDLE) ? data_sram_we : we_q;
  assign req_size  = (state == S_IDLE) ? (data_sram_we ? data_sram_write_mode : data_sram_mode)
                                       : size_q;
  assign req_us    = (state == S_IDLE) ? data_sram_us : us_q;
  assign req_idx   = req_addr[AW-1:2];

  // Edge that enters RESP: array access and response capture happen here.
  always_comb begin
    go_resp = 1'b0;
    case (state)
      S_IDLE:  go_resp = data_sram_en && (WAIT_CYCLES == 0);
      S_WAIT:  go_resp = (wait_cnt == 4'd0);
      default: go_resp = 1'b0;
    endcase
  end

  // Size/alignment checking plus store lane enables and replicated lane data.
  always_comb begin
    req_err   = 1'b0;
    lane_en   = 4'b0000;
    lane_data = req_wdata;
    case (req_size)
      3'b001: begin
        lane_en   = 4'b0001 << req_addr[1:0];
        lane_data = {4{req_wdata[7:0]}};
      end
      3'b010: begin
        req_err   = req_addr[0];
        lane_en   = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
      end
      3'b100: begin
        req_err   = (req_addr[1:0] != 2'b00);
        lane_en   = 4'b1111;
      end
      default: req_err = 1'b1;
    endcase
  end

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lo,
                                               input logic [2:0]  size,
                                               input logic        us);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {lo, 3'b000};
    res = 32'd0;
    case (size)
      3'b001:  res = us ? {24'd0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
      3'b010:  res = us ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      3'b100:  res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Control FSM and wait-state counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (data_sram_en) begin
            state    <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request fields captured on handshake acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= data_sram_addr[AW-1:0];
      wdata_q <= data_sram_wdata;
      we_q    <= data_sram_we;
      size_q  <= data_sram_we ? data_sram_write_mode : data_sram_mode;
      us_q    <= data_sram_us;
    end
  end

  // Storage array: lane-masked store on entry to RESP; contents never reset.
  always_ff @(posedge clk) begin
    if (go_resp && req_we && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[req_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  // Response registers: hold their value until the next response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (go_resp) begin
      err_q   <= req_err;
      rdata_q <= (req_err || req_we) ? 32'd0
                 : load_extract(mem[req_idx], req_addr[1:0], req_size, req_us);
    end
  end

  assign data_sram_ready  = (state == S_IDLE);
  assign data_sram_rvalid = (state == S_RESP);
  assign data_sram_rdata  = rdata_q;
  assign data_sram_err    = err_q;

`ifdef DATA_SRAM_STAT_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;
  logic [15:0] err_cnt_q;

  // Saturating completion counters, stepped once per response strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q  <= 16'd0;
      wr_cnt_q  <= 16'd0;
      err_cnt_q <= 16'd0;
    end else if (state == S_RESP) begin
      if (err_q) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (we_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign data_sram_rd_cnt  = rd_cnt_q;
  assign data_sram_wr_cnt  = wr_cnt_q;
  assign data_sram_err_cnt = err_cnt_q;
`else
  assign data_sram_rd_cnt  = 16'd0;
  assign data_sram_wr_cnt  = 16'd0;
  assign data_sram_err_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_resp
// Description : Directed self-checking bench for data_sram_resp. One instance
//               runs with two wait states, a second with zero wait states;
//               a select bit routes the shared request bus to one of them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, we, us, sel;
  logic [31:0] addr, wdata;
  logic [2:0]  mode, wmode;

  logic        en2, en0;
  logic        ready2, rvalid2, err2, ready0, rvalid0, err0;
  logic [31:0] rdata2, rdata0;
  logic [15:0] rdc2, wrc2, erc2, rdc0, wrc0, erc0;

  logic        ready, rvalid, err;
  logic [31:0] rdata;
  logic [15:0] rd_cnt, wr_cnt, err_cnt;

  int vectors    = 0;
  int miscompares = 0;
  int t_rd = 0, t_wr = 0, t_err = 0;

  always #5 clk = ~clk;

  assign en2 = en & ~sel;
  assign en0 = en & sel;

  assign ready   = sel ? ready0  : ready2;
  assign rvalid  = sel ? rvalid0 : rvalid2;
  assign rdata   = sel ? rdata0  : rdata2;
  assign err     = sel ? err0    : err2;
  assign rd_cnt  = sel ? rdc0    : rdc2;
  assign wr_cnt  = sel ? wrc0    : wrc2;
  assign err_cnt = sel ? erc0    : erc2;

  data_sram_resp #(.DEPTH_LOG2(12), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset),
    .data_sram_en(en2), .data_sram_we(we), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_mode(mode), .data_sram_write_mode(wmode),
    .data_sram_us(us), .data_sram_ready(ready2), .data_sram_rvalid(rvalid2),
    .data_sram_rdata(rdata2), .data_sram_err(err2),
    .data_sram_rd_cnt(rdc2), .data_sram_wr_cnt(wrc2), .data_sram_err_cnt(erc2)
  );

  data_sram_resp #(.DEPTH_LOG2(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .data_sram_en(en0), .data_sram_we(we), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_mode(mode), .data_sram_write_mode(wmode),
    .data_sram_us(us), .data_sram_ready(ready0), .data_sram_rvalid(rvalid0),
    .data_sram_rdata(rdata0), .data_sram_err(err0),
    .data_sram_rd_cnt(rdc0), .data_sram_wr_cnt(wrc0), .data_sram_err_cnt(erc0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
`ifdef DATA_SRAM_STAT_EN
    chk({tag, "_rd_cnt"},  {16'd0, rd_cnt},  32'(t_rd));
    chk({tag, "_wr_cnt"},  {16'd0, wr_cnt},  32'(t_wr));
    chk({tag, "_err_cnt"}, {16'd0, err_cnt}, 32'(t_err));
`else
    chk({tag, "_rd_cnt"},  {16'd0, rd_cnt},  32'd0);
    chk({tag, "_wr_cnt"},  {16'd0, wr_cnt},  32'd0);
    chk({tag, "_err_cnt"}, {16'd0, err_cnt}, 32'd0);
`endif
  endtask

  // One complete request; called at #1 after a posedge with the target idle.
  // The unused size field carries an illegal code so a wrong size select errs.
  task automatic do_req(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] sz, input logic u,
                        input logic [31:0] exp_rd, input logic exp_e, input int exp_lat);
    int   lat;
    logic rdy_bad;
    en    = 1'b1;
    we    = w;
    addr  = a;
    wdata = wd;
    us    = u;
    mode  = w ? 3'b011 : sz;
    wmode = w ? sz : 3'b011;
    chk({tag, "_ready_idle"}, {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    en      = 1'b0;
    lat     = 1;
    rdy_bad = 1'b0;
    while (!rvalid && lat < 40) begin
      if (ready) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (ready) rdy_bad = 1'b1;
    chk({tag, "_latency"},   32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"},     rdata, exp_rd);
    chk({tag, "_err"},       {31'd0, err}, {31'd0, exp_e});
    chk({tag, "_ready_busy"}, {31'd0, rdy_bad}, 32'd0);
    if (exp_e)  t_err++;
    else if (w) t_wr++;
    else        t_rd++;
    @(posedge clk); #1;
    chk({tag, "_rvalid_drop"}, {31'd0, rvalid}, 32'd0);
    chk({tag, "_rdata_hold"},  rdata, exp_rd);
  endtask

  initial begin
    int   k;
    logic saw_rvalid;
    reset = 1'b1;
    en = 1'b0; we = 1'b0; us = 1'b0; sel = 1'b0;
    addr = 32'd0; wdata = 32'd0; mode = 3'b100; wmode = 3'b100;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",  {31'd0, ready},  32'd1);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata",  rdata,           32'd0);
    chk("rst_err",    {31'd0, err},    32'd0);
    chk_counters("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Two wait states: store/load round trip, latency 3.
    do_req("st_w10",  1'b1, 32'h10, 32'hDEADBEEF, 3'b100, 1'b0, 32'h0,        1'b0, 3);
    do_req("ld_w10",  1'b0, 32'h10, 32'h0,        3'b100, 1'b0, 32'hDEADBEEF, 1'b0, 3);
    // Byte store into lane 3 and extended byte loads.
    do_req("st_b13",  1'b1, 32'h13, 32'h12345680, 3'b001, 1'b0, 32'h0,        1'b0, 3);
    do_req("ld_b13s", 1'b0, 32'h13, 32'h0,        3'b001, 1'b0, 32'hFFFFFF80, 1'b0, 3);
    do_req("ld_b13u", 1'b0, 32'h13, 32'h0,        3'b001, 1'b1, 32'h00000080, 1'b0, 3);
    do_req("ld_w10b", 1'b0, 32'h10, 32'h0,        3'b100, 1'b1, 32'h80ADBEEF, 1'b0, 3);
    // Misaligned accesses.
    do_req("ld_h11",  1'b0, 32'h11, 32'h0,        3'b010, 1'b0, 32'h0,        1'b1, 3);
    do_req("ld_w12",  1'b0, 32'h12, 32'h0,        3'b100, 1'b0, 32'h0,        1'b1, 3);
    do_req("st_h11",  1'b1, 32'h11, 32'h00005555, 3'b010, 1'b0, 32'h0,        1'b1, 3);
    do_req("ld_w10c", 1'b0, 32'h10, 32'h0,        3'b100, 1'b0, 32'h80ADBEEF, 1'b0, 3);
    // Upper half store and half loads with both extensions.
    do_req("st_h12",  1'b1, 32'h12, 32'h9999CAFE, 3'b010, 1'b0, 32'h0,        1'b0, 3);
    do_req("ld_h12s", 1'b0, 32'h12, 32'h0,        3'b010, 1'b0, 32'hFFFFCAFE, 1'b0, 3);
    do_req("ld_h10u", 1'b0, 32'h10, 32'h0,        3'b010, 1'b1, 32'h0000BEEF, 1'b0, 3);
    // Bad size encoding on a load.
    do_req("ld_m011", 1'b0, 32'h10, 32'h0,        3'b011, 1'b0, 32'h0,        1'b1, 3);
    chk_counters("after_m011");

    // Reset during the wait states of an accepted store.
    en = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h11111111;
    wmode = 3'b100; mode = 3'b011; us = 1'b0;
    @(posedge clk); #1;
    en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #6;
    reset = 1'b0;
    t_rd = 0; t_wr = 0; t_err = 0;
    saw_rvalid = 1'b0;
    for (k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rvalid) saw_rvalid = 1'b1;
    end
    chk("midrst_no_rvalid", {31'd0, saw_rvalid}, 32'd0);
    chk_counters("midrst");
    do_req("ld_w10r", 1'b0, 32'h10, 32'h0, 3'b100, 1'b0, 32'hCAFEBEEF, 1'b0, 3);

    // Zero wait states: address wrap and one-cycle latency.
    sel = 1'b1;
    t_rd = 0; t_wr = 0; t_err = 0;
    @(posedge clk); #1;
    do_req("z_st_wrap", 1'b1, 32'h00004004, 32'h12345678, 3'b100, 1'b0, 32'h0,        1'b0, 1);
    do_req("z_ld_4",    1'b0, 32'h00000004, 32'h0,        3'b100, 1'b0, 32'h12345678, 1'b0, 1);
    do_req("z_ld_b5",   1'b0, 32'h00000005, 32'h0,        3'b001, 1'b0, 32'h00000056, 1'b0, 1);
    chk_counters("zero_wait");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
